// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Operands are latched at start; results land in HI/LO after a fixed per-op latency.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              busy_q, busy_d;

    logic [63:0]       prod_s;
    logic [63:0]       prod_u;
    logic [31:0]       a_mag, b_mag, den_s, den_u;
    logic [31:0]       sq_mag, sr_mag;
    logic [31:0]       quo_s, rem_s, quo_u, rem_u;
    logic              b_zero;

    // Arithmetic always works from the latched operands, never the live buses.
    always_comb begin
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

        b_zero = (b_q == 32'd0);
        a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
        b_mag  = b_q[31] ? (~b_q + 32'd1) : b_q;
        // Substitute 1 for a zero divisor; the result is discarded anyway.
        den_s  = b_zero ? 32'd1 : b_mag;
        den_u  = b_zero ? 32'd1 : b_q;

        // Magnitude division sidesteps the 0x80000000 / -1 overflow case.
        sq_mag = a_mag / den_s;
        sr_mag = a_mag % den_s;
        quo_s  = (a_q[31] ^ b_q[31]) ? (~sq_mag + 32'd1) : sq_mag;
        rem_s  = a_q[31] ? (~sr_mag + 32'd1) : sr_mag;

        quo_u  = a_q / den_u;
        rem_u  = a_q % den_u;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (MDUOp)
                        OpMult, OpMultu: begin
                            op_d    = MDUOp;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CntW'(MULT_CYCLES);
                            state_d = StRun;
                        end
                        OpDiv, OpDivu: begin
                            op_d    = MDUOp;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CntW'(DIV_CYCLES);
                            state_d = StRun;
                        end
                        OpMthi:  hi_d = A;
                        OpMtlo:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    case (op_q)
                        OpMult:  {hi_d, lo_d} = prod_s;
                        OpMultu: {hi_d, lo_d} = prod_u;
                        OpDiv: begin
                            if (!b_zero) begin
                                hi_d = rem_s;
                                lo_d = quo_s;
                            end
                        end
                        OpDivu: begin
                            if (!b_zero) begin
                                hi_d = rem_u;
                                lo_d = quo_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
